// File: rtl/square_ram_arbiter.sv
// Round-robin arbiter sharing one square {x, y} RAM between two requesters, with a full-plane clear engine.
// Optional grant/conflict statistics counters are enabled by defining SQUARE_RAM_ARB_STATS_EN.
//
// state | meaning
// IDLE  | arbitrate requesters onto the RAM
// CLEAR | sweep every {x, y} writing CLEAR_VALUE; requesters stall
module square_ram_arbiter #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 12,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [ADDR_WIDTH-1:0] req_x0,
    input  logic [ADDR_WIDTH-1:0] req_y0,
    input  logic [ADDR_WIDTH-1:0] req_x1,
    input  logic [ADDR_WIDTH-1:0] req_y1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data0,
    output logic [DATA_WIDTH-1:0] rsp_data1,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_x,
    output logic [ADDR_WIDTH-1:0] ram_y,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef SQUARE_RAM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_grants0,
    output logic [31:0]           stat_grants1,
    output logic [31:0]           stat_conflicts
`endif
);

    localparam int CNT_W = 2 * ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             rr_last;
    logic [CNT_W-1:0] clear_cnt;
    logic             cnt_last;
    logic             grant_any;
    logic             grant_idx;

    assign cnt_last = (clear_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_start) state_nxt = CLEAR;
            CLEAR:   if (cnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant goes to the requester that did not win last time when both compete.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        if (state == IDLE) begin
            if (req_valid[0] && req_valid[1]) begin
                grant_any = 1'b1;
                grant_idx = ~rr_last;
            end else if (req_valid[0]) begin
                grant_any = 1'b1;
                grant_idx = 1'b0;
            end else if (req_valid[1]) begin
                grant_any = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready  = 2'b00;
        ram_we     = 1'b0;
        ram_x      = '0;
        ram_y      = '0;
        ram_wdata  = '0;
        clear_busy = (state == CLEAR);
        if (reset_n) begin
            if (state == CLEAR) begin
                ram_we         = 1'b1;
                ram_wdata      = CLEAR_VALUE;
                {ram_x, ram_y} = clear_cnt;
            end else if (grant_any) begin
                if (grant_idx) begin
                    req_ready = 2'b10;
                    ram_we    = req_write[1];
                    ram_x     = req_x1;
                    ram_y     = req_y1;
                    ram_wdata = req_wdata1;
                end else begin
                    req_ready = 2'b01;
                    ram_we    = req_write[0];
                    ram_x     = req_x0;
                    ram_y     = req_y0;
                    ram_wdata = req_wdata0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last    <= 1'b1;
            clear_cnt  <= '0;
            clear_done <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data0  <= '0;
            rsp_data1  <= '0;
        end else begin
            rsp_valid  <= 2'b00;
            clear_done <= 1'b0;
            if (grant_any) begin
                rr_last <= grant_idx;
            end
            if (req_ready[0] && !req_write[0]) begin
                rsp_valid[0] <= 1'b1;
                rsp_data0    <= ram_rdata;
            end
            if (req_ready[1] && !req_write[1]) begin
                rsp_valid[1] <= 1'b1;
                rsp_data1    <= ram_rdata;
            end
            if (state == CLEAR) begin
                if (cnt_last) begin
                    clear_cnt  <= '0;
                    clear_done <= 1'b1;
                end else begin
                    clear_cnt <= clear_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef SQUARE_RAM_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants0   <= '0;
            stat_grants1   <= '0;
            stat_conflicts <= '0;
        end else begin
            if (req_ready[0] && req_valid[0] && (stat_grants0 != 32'hFFFF_FFFF)) begin
                stat_grants0 <= stat_grants0 + 32'd1;
            end
            if (req_ready[1] && req_valid[1] && (stat_grants1 != 32'hFFFF_FFFF)) begin
                stat_grants1 <= stat_grants1 + 32'd1;
            end
            if ((state == IDLE) && (req_valid == 2'b11) && (stat_conflicts != 32'hFFFF_FFFF)) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule
